multicycle_subtractor_n_bits: RTL and testbench

//  Parametrised multi-cycle ripple subtractor: computes S = A - B - BIN over WIDTH bits, SLICE bits per clock.

---
 rtl/multicycle_subtractor_n_bits_pkg.sv | 19 +
 rtl/multicycle_subtractor_n_bits_if.sv | 52 +++++
 rtl/multicycle_subtractor_n_bits_slice.sv | 39 +++
 rtl/multicycle_subtractor_n_bits.sv | 145 ++++++++++++++
 tb/tb_multicycle_subtractor_n_bits.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/multicycle_subtractor_n_bits_pkg.sv
// Shared types and sizing helpers for the multi-cycle subtractor.
// Optional feature macro: ADD_SUB_MODE_EN (adds a MODE input selecting add).
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    function automatic int slice_count(input int width, input int slice);
        return width / slice;
    endfunction

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/multicycle_subtractor_n_bits_if.sv
// Operand/result handshake bundle for the multi-cycle subtractor.
// Optional feature macro: ADD_SUB_MODE_EN (adds MODE, latched with operands).
interface multicycle_subtractor_n_bits_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic             READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BIN;
`ifdef ADD_SUB_MODE_EN
    logic             MODE;
`endif
    logic [WIDTH-1:0] S;
    logic             BOUT;
    logic             OVF;
    logic             OUT_VALID;
    logic             OUT_READY;

    modport master (
`ifdef ADD_SUB_MODE_EN
        output MODE,
`endif
        output START,
        output A,
        output B,
        output BIN,
        output OUT_READY,
        input  READY,
        input  S,
        input  BOUT,
        input  OVF,
        input  OUT_VALID
    );

    modport slave (
`ifdef ADD_SUB_MODE_EN
        input  MODE,
`endif
        input  START,
        input  A,
        input  B,
        input  BIN,
        input  OUT_READY,
        output READY,
        output S,
        output BOUT,
        output OVF,
        output OUT_VALID
    );

endinterface

// File: rtl/multicycle_subtractor_n_bits_slice.sv
// SLICE-bit ripple of full-subtractor cells (full-adder cells when mode=1).
// Optional feature macro: ADD_SUB_MODE_EN (adds the mode input).
module subtractor_slice #(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             bin,
`ifdef ADD_SUB_MODE_EN
    input  logic             mode,
`endif
    output logic [SLICE-1:0] s,
    output logic             bout
);

    logic [SLICE:0]   chain;
    logic [SLICE-1:0] a_gen;

    // A borrow cell is a carry cell with the minuend bit inverted.
`ifdef ADD_SUB_MODE_EN
    assign a_gen = mode ? a : ~a;
`else
    assign a_gen = ~a;
`endif

    always_comb begin
        chain    = '0;
        s        = '0;
        chain[0] = bin;
        for (int i = 0; i < SLICE; i++) begin
            s[i]       = a[i] ^ b[i] ^ chain[i];
            chain[i+1] = (a_gen[i] & b[i])
                       | ((a_gen[i] ^ b[i]) & chain[i]);
        end
    end

    assign bout = chain[SLICE];

endmodule

// File: rtl/multicycle_subtractor_n_bits.sv
// Multi-cycle ripple subtractor: S = A - B - BIN, SLICE bits per clock.
// Optional feature macro: ADD_SUB_MODE_EN (MODE=1 selects A + B + BIN).
module multicycle_subtractor_n_bits
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic CLK,
    input  logic RST,
    multicycle_subtractor_n_bits_if.slave bus
);

    localparam int N  = slice_count(WIDTH, SLICE);
    localparam int CW = count_width(N);
    localparam int M  = WIDTH - 1;

    generate
        if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("WIDTH must be >= 2 and a multiple of SLICE");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] s_q;
    logic             borrow_q;
    logic             bout_q;
    logic             ovf_q;
    logic             ovf_nxt;
    logic             mode_q;
    logic             last;
    logic             accept;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_s;
    logic             sl_bout;

    assign last   = (cnt == CW'(N - 1));
    assign accept = (state == IDLE) && bus.START;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.READY     = 1'b0;
        bus.OUT_VALID = 1'b0;
        case (state)
            IDLE: begin
                bus.READY = 1'b1;
                if (bus.START) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = HOLD;
            end
            HOLD: begin
                bus.OUT_VALID = 1'b1;
                if (bus.OUT_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt == CW'(k)) begin
                sl_a = a_q[k*SLICE +: SLICE];
                sl_b = b_q[k*SLICE +: SLICE];
            end
        end
    end

    always_comb begin
        acc_nxt = acc_q;
        for (int k = 0; k < N; k++) begin
            if (cnt == CW'(k)) acc_nxt[k*SLICE +: SLICE] = sl_s;
        end
    end

    subtractor_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .bin  (borrow_q),
`ifdef ADD_SUB_MODE_EN
        .mode (mode_q),
`endif
        .s    (sl_s),
        .bout (sl_bout)
    );

    // Operand signs differ for subtract, match for add.
    assign ovf_nxt = ((a_q[M] ^ b_q[M]) ^ mode_q)
                   && (acc_nxt[M] != a_q[M]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            s_q      <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mode_q   <= 1'b0;
        end else if (accept) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            borrow_q <= bus.BIN;
            cnt      <= '0;
            acc_q    <= '0;
`ifdef ADD_SUB_MODE_EN
            mode_q   <= bus.MODE;
`else
            mode_q   <= 1'b0;
`endif
        end else if (state == RUN) begin
            acc_q    <= acc_nxt;
            borrow_q <= sl_bout;
            cnt      <= cnt + CW'(1);
            if (last) begin
                s_q    <= acc_nxt;
                bout_q <= sl_bout;
                ovf_q  <= ovf_nxt;
            end
        end
    end

    assign bus.S    = s_q;
    assign bus.BOUT = bout_q;
    assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_multicycle_subtractor_n_bits.sv
// Directed and random checks of the multi-cycle subtractor against an arithmetic model.
module tb_multicycle_subtractor_n_bits;

    localparam int W  = 8;
    localparam int SL = 2;
    localparam int N  = W / SL;
`ifdef ADD_SUB_MODE_EN
    localparam bit HAS_MODE = 1'b1;
`else
    localparam bit HAS_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic mode_v;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_subtractor_n_bits_if #(.WIDTH(W)) bus ();

`ifdef ADD_SUB_MODE_EN
    assign bus.MODE = mode_v;
`endif

    multicycle_subtractor_n_bits #(
        .WIDTH (W),
        .SLICE (SL)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, bout, s} from integer arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic bin,
                                           input logic m);
        int ua, ub, sa, sb, u, sg;
        logic bo, ov;
        logic [W-1:0] s;
        ua = int'(a);
        ub = int'(b);
        sa = ua - (a[W-1] ? (1 << W) : 0);
        sb = ub - (b[W-1] ? (1 << W) : 0);
        if (m) begin
            u  = ua + ub + int'(bin);
            sg = sa + sb + int'(bin);
            bo = (u >= (1 << W));
        end else begin
            u  = ua - ub - int'(bin);
            sg = sa - sb - int'(bin);
            bo = (u < 0);
        end
        s  = u[W-1:0];
        ov = (sg > (1 << (W-1)) - 1) || (sg < -(1 << (W-1)));
        return {ov, bo, s};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic m,
                          input int stall, input string tag);
        logic [W+1:0] exp;
        logic         me;
        int           lat;
        me = m & HAS_MODE;
        exp = model(a, b, bin, me);
        check({tag, "_ready_idle"}, bus.READY, 1);
        bus.A = a;
        bus.B = b;
        bus.BIN = bin;
        mode_v = me;
        bus.OUT_READY = (stall == 0);
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.A = W'($urandom);
        bus.B = W'($urandom);
        bus.BIN = 1'($urandom);
        mode_v = 1'($urandom) & HAS_MODE;
        lat = 0;
        while (!bus.OUT_VALID && lat < 4 * N + 4) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, N);
        check({tag, "_s"}, bus.S, exp[W-1:0]);
        check({tag, "_bout"}, bus.BOUT, exp[W]);
        check({tag, "_ovf"}, bus.OVF, exp[W+1]);
        check({tag, "_ready_busy"}, bus.READY, 0);
        for (int i = 0; i < stall; i++) begin
            bus.START = 1'b1;
            bus.A = ~a;
            tick();
            check({tag, "_hold_valid"}, bus.OUT_VALID, 1);
            check({tag, "_hold_ready"}, bus.READY, 0);
            check({tag, "_hold_s"}, bus.S, exp[W-1:0]);
        end
        bus.START = 1'b0;
        bus.OUT_READY = 1'b1;
        tick();
        check({tag, "_done_ready"}, bus.READY, 1);
        check({tag, "_done_valid"}, bus.OUT_VALID, 0);
        check({tag, "_kept_s"}, bus.S, exp[W-1:0]);
    endtask

    initial begin
        rst = 1'b1;
        mode_v = 1'b0;
        bus.START = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.BIN = 1'b0;
        bus.OUT_READY = 1'b1;
        tick();
        tick();
        check("rst_ready", bus.READY, 1);
        check("rst_valid", bus.OUT_VALID, 0);
        check("rst_s", bus.S, 0);
        check("rst_bout", bus.BOUT, 0);
        check("rst_ovf", bus.OVF, 0);
        rst = 1'b0;
        tick();

        run_op(8'hFF, 8'h00, 1'b0, 1'b0, 0, "ff_minus_0");
        run_op(8'h00, 8'h01, 1'b0, 1'b0, 0, "0_minus_1");
        run_op(8'h80, 8'h01, 1'b0, 1'b0, 0, "ovf_neg");
        run_op(8'h10, 8'h0F, 1'b1, 1'b0, 0, "ripple");
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 5, "stall5");

        // Abort an operation part way through the slices.
        bus.A = 8'h12;
        bus.B = 8'h34;
        bus.BIN = 1'b0;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_ready", bus.READY, 1);
        check("midrun_valid", bus.OUT_VALID, 0);
        check("midrun_s", bus.S, 0);
        check("midrun_bout", bus.BOUT, 0);
        check("midrun_ovf", bus.OVF, 0);
        run_op(8'h34, 8'h12, 1'b1, 1'b0, 0, "after_rst");

        if (HAS_MODE) begin
            run_op(8'h7F, 8'h01, 1'b0, 1'b1, 0, "add_ovf");
            run_op(8'hFF, 8'h01, 1'b1, 1'b1, 1, "add_carry");
        end

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   1'($urandom), int'($urandom_range(0, 3)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
